// File: rtl/gelato_l2_arbiter.sv
// gelato_l2_arbiter
// Merges the per-SM instruction/data L2 request channels into one L2/memory
// port. Round-robin grant, one transaction in flight, and each response is
// routed back only to the requester that issued it.
// Port 2*i is SM i instruction fetch; port 2*i+1 is SM i data.
// Optional performance counters are enabled by defining GELATO_L2_ARB_PERF_EN.
module gelato_l2_arbiter #(
  parameter int NUM_PORTS  = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rdy,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_PORTS-1:0]             req_we,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic                             mem_we,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  output logic [31:0]                      perf_grants,
  output logic [31:0]                      perf_stall_cycles
);

  localparam int SW = IDX_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state;
  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IDX_WIDTH-1:0] grant;
  logic [IDX_WIDTH-1:0] pick_idx;
  logic                 pick_found;
  logic [SW-1:0]        scan_idx;
  logic                 grant_now;

  // Find the first valid requester at or after rr_ptr, wrapping around the top
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = {1'b0, rr_ptr} + SW'(k);
      if (scan_idx >= SW'(NUM_PORTS)) begin
        scan_idx = scan_idx - SW'(NUM_PORTS);
      end
      if (!pick_found && req_valid[scan_idx[IDX_WIDTH-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[IDX_WIDTH-1:0];
      end
    end
  end

  // Grant only from IDLE while enabled; held off while reset is asserted so outputs stay quiet
  assign grant_now = (state == IDLE) && rdy && pick_found && rst_n;
  assign req_ready = grant_now ? (NUM_PORTS'(1) << pick_idx) : '0;

  // Transaction FSM: latch the winner, issue downstream, wait, then route the response back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_now) begin
            grant         <= pick_idx;
            mem_addr      <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata     <= req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            mem_we        <= req_we[pick_idx];
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            rsp_data  <= mem_rsp_data;
            rsp_valid <= NUM_PORTS'(1) << grant;
            state     <= RESP;
          end
        end
        RESP: begin
          rr_ptr <= (grant == IDX_WIDTH'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GELATO_L2_ARB_PERF_EN
  // Count grants and cycles spent stalled by downstream backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grants       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (grant_now) begin
        perf_grants <= perf_grants + 32'd1;
      end
      if ((state == ISSUE) && !mem_req_ready) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`else
  assign perf_grants       = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_gelato_l2_arbiter.sv
// tb_gelato_l2_arbiter
// Directed bench for gelato_l2_arbiter. Inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising (active) edge.
// Perf counter expectations follow GELATO_L2_ARB_PERF_EN.
module tb_gelato_l2_arbiter;

  localparam int NP = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rdy;
  logic [NP-1:0]    req_valid;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]    req_we;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_we;
  logic             mem_rsp_valid;
  logic [DW-1:0]    mem_rsp_data;
  logic [31:0]      perf_grants;
  logic [31:0]      perf_stall_cycles;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] port_addr [NP];

  gelato_l2_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rdy              (rdy),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_we           (req_we),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_we           (mem_we),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data),
    .perf_grants      (perf_grants),
    .perf_stall_cycles(perf_stall_cycles)
  );

  // 10ns clock
  always #5 clk = ~clk;

  // Guard against a stuck simulation
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation ran past its time limit, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic setPort(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
    port_addr[p]            = a;
    req_addr[p*AW +: AW]    = a;
    req_wdata[p*DW +: DW]   = d;
    req_we[p]               = we;
  endtask

  task automatic applyStimulus(input logic [NP-1:0] valid, input logic enable, input logic mem_ready);
    req_valid     = valid;
    rdy           = enable;
    mem_req_ready = mem_ready;
  endtask

  // One zero-stall transaction starting in IDLE: grant, issue, response one cycle after accept
  task automatic runTransaction(input int p, input logic [DW-1:0] d);
    logic [NP-1:0] one;
    one = NP'(1) << p;
    #1 checkOutput("grant", req_ready, one);
    nextCycle();
    #1 checkOutput("issue_addr", mem_addr, port_addr[p]);
    checkOutput("issue_valid", mem_req_valid, 1);
    nextCycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    nextCycle();
    mem_rsp_valid = 1'b0;
    #1 checkOutput("rsp_valid", rsp_valid, one);
    checkOutput("rsp_data", rsp_data, d);
    nextCycle();
  endtask

  initial begin
    rst_n         = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    req_we        = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    applyStimulus('0, 1'b0, 1'b0);
    for (int p = 0; p < NP; p++) begin
      setPort(p, 32'h1000_0000 + AW'(p * 256), 32'hA000_0000 + DW'(p), 1'b0);
    end

    // Reset state
    repeat (2) nextCycle();
    #1 checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_mem_req_valid", mem_req_valid, 0);
    checkOutput("reset_mem_addr", mem_addr, 0);
    checkOutput("reset_rsp_data", rsp_data, 0);
    checkOutput("reset_perf_grants", perf_grants, 0);
    nextCycle();
    rst_n = 1'b1;

    // Single read on port 3 with minimum round trip
    setPort(3, 32'h0000_1000, 32'h0, 1'b0);
    applyStimulus(8'h08, 1'b1, 1'b1);
    #1 checkOutput("single_ready_T", req_ready, 8'h08);
    nextCycle();
    req_valid = '0;
    #1 checkOutput("single_issue_valid", mem_req_valid, 1);
    checkOutput("single_issue_addr", mem_addr, 32'h1000);
    checkOutput("single_issue_we", mem_we, 0);
    nextCycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    #1 checkOutput("single_no_early_rsp", rsp_valid, 0);
    nextCycle();
    mem_rsp_valid = 1'b0;
    #1 checkOutput("single_rsp_valid", rsp_valid, 8'h08);
    checkOutput("single_rsp_data", rsp_data, 32'hDEAD_BEEF);
    nextCycle();
    #1 checkOutput("single_rsp_pulse", rsp_valid, 0);
    checkOutput("single_rsp_hold", rsp_data, 32'hDEAD_BEEF);

    // Round-robin: all ports requesting from reset, order 0..7 then 0
    rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(8'hFF, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) begin
      runTransaction(k % NP, 32'hC0DE_0000 + DW'(k));
    end
    req_valid = '0;

    // Backpressure: port 1 write held in ISSUE for 5 stalled cycles
    setPort(1, 32'h0000_0020, 32'h0000_0055, 1'b1);
    applyStimulus(8'h02, 1'b1, 1'b0);
    #1 checkOutput("bp_ready", req_ready, 8'h02);
    for (int c = 0; c < 6; c++) begin
      nextCycle();
      req_valid     = '0;
      mem_req_ready = (c == 5);
      #1 checkOutput("bp_valid", mem_req_valid, 1);
      checkOutput("bp_addr", mem_addr, 32'h20);
      checkOutput("bp_wdata", mem_wdata, 32'h55);
      checkOutput("bp_we", mem_we, 1);
    end
    nextCycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_55AA;
    #1 checkOutput("bp_valid_dropped", mem_req_valid, 0);
    nextCycle();
    mem_rsp_valid = 1'b0;
    #1 checkOutput("bp_rsp_valid", rsp_valid, 8'h02);
    checkOutput("bp_rsp_data", rsp_data, 32'h55AA);
`ifdef GELATO_L2_ARB_PERF_EN
    checkOutput("bp_perf_stall", perf_stall_cycles, 5);
    checkOutput("bp_perf_grants", perf_grants, 10);
`else
    checkOutput("bp_perf_stall", perf_stall_cycles, 0);
    checkOutput("bp_perf_grants", perf_grants, 0);
`endif
    nextCycle();

    // rdy low blocks new grants
    applyStimulus(8'hFF, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      #1 checkOutput("rdy_low_ready", req_ready, 0);
      checkOutput("rdy_low_mem_valid", mem_req_valid, 0);
      nextCycle();
    end

    // rdy dropped mid-transaction does not stop the response
    rdy = 1'b1;
    #1 checkOutput("rdy_grant", req_ready, 8'h04);
    nextCycle();
    applyStimulus('0, 1'b0, 1'b1);
    nextCycle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1234_5678;
    nextCycle();
    mem_rsp_valid = 1'b0;
    #1 checkOutput("rdy_wait_rsp_valid", rsp_valid, 8'h04);
    checkOutput("rdy_wait_rsp_data", rsp_data, 32'h1234_5678);
    nextCycle();

    // Async reset while in WAIT, then first grant from pointer 0
    applyStimulus(8'h0A, 1'b1, 1'b1);
    #1 checkOutput("arst_grant", req_ready, 8'h08);
    nextCycle();
    req_valid = 8'h12;
    nextCycle();
    #2 rst_n = 1'b0;
    #1 checkOutput("arst_mem_valid", mem_req_valid, 0);
    checkOutput("arst_rsp_valid", rsp_valid, 0);
    checkOutput("arst_req_ready", req_ready, 0);
    checkOutput("arst_rsp_data", rsp_data, 0);
    checkOutput("arst_mem_addr", mem_addr, 0);
    checkOutput("arst_mem_wdata", mem_wdata, 0);
    nextCycle();
    rst_n = 1'b1;
    runTransaction(1, 32'h0BAD_F00D);
    req_valid = '0;

    // Spurious downstream response in IDLE
    rdy           = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD0_0001;
    nextCycle();
    mem_rsp_valid = 1'b0;
    #1 checkOutput("spur_idle_rsp_valid", rsp_valid, 0);
    checkOutput("spur_idle_rsp_data", rsp_data, 32'h0BAD_F00D);

    // Spurious downstream response in ISSUE
    applyStimulus(8'h40, 1'b1, 1'b0);
    #1 checkOutput("spur_grant", req_ready, 8'h40);
    nextCycle();
    req_valid     = '0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD0_0002;
    nextCycle();
    mem_rsp_valid = 1'b0;
    #1 checkOutput("spur_issue_rsp_valid", rsp_valid, 0);
    checkOutput("spur_issue_rsp_data", rsp_data, 32'h0BAD_F00D);
    checkOutput("spur_issue_still_valid", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    nextCycle();
    #1 checkOutput("spur_wait_rsp_valid", rsp_valid, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_600D;
    nextCycle();
    mem_rsp_valid = 1'b0;
    #1 checkOutput("spur_final_rsp_valid", rsp_valid, 8'h40);
    checkOutput("spur_final_rsp_data", rsp_data, 32'h600D);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
